// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: CPU-side sample FIFO feeding the PWM DAC over req/ack.
// Ports: clk/rst; enable; wr_valid/wr_data/wr_ready, count;
//        underrun/clr_underrun; duty_cycle/req to DAC, ack from DAC.
module dac_sample_feeder #(
    parameter int WIDTH       = 12,
    parameter int DEPTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     wr_valid,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     wr_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underrun,
    input  logic                     clr_underrun,
    output logic [WIDTH-1:0]         duty_cycle,
    output logic                     req,
    input  logic                     ack
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0]       mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   ack_s;
    logic                   primed;
    logic                   push;
    logic                   pop;
    logic                   underrun_set;

    assign wr_ready = (count != FULL);
    assign push     = wr_valid && wr_ready;
    assign ack_s    = sync_q[SYNC_STAGES-1];

    assign underrun_set = (state_q == IDLE) && enable
                          && primed && (count == '0);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && (count != '0) && !ack_s) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = REQ;
            REQ: begin
                if (ack_s) state_d = RELEASE;
            end
            RELEASE: begin
                if (!ack_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sample storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            req        <= 1'b0;
            sync_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            duty_cycle <= '0;
            primed     <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q <= state_d;
            req     <= (state_d == REQ);
            sync_q  <= {sync_q[SYNC_STAGES-2:0], ack};

            if (push) wr_ptr <= wr_ptr + AW'(1);

            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                duty_cycle <= mem[rd_ptr];
                primed     <= 1'b1;
            end

            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);

            // Set dominates a coincident clear.
            if (underrun_set)
                underrun <= 1'b1;
            else if (clr_underrun)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: directed bench for dac_sample_feeder.
// Drives inputs at negedge, samples outputs at negedge.
module tb_dac_sample_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        wr_valid = 1'b0;
    logic [11:0] wr_data = '0;
    logic        wr_ready;
    logic [5:0]  count;
    logic        underrun;
    logic        clr_underrun = 1'b0;
    logic [11:0] duty_cycle;
    logic        req;
    logic        ack = 1'b0;

    int n_run  = 0;
    int n_fail = 0;

    bit          dac_auto = 1'b0;
    int          req_cnt  = 0;
    logic [11:0] rx_q[$];

    always #5 clk = ~clk;

    dac_sample_feeder #(
        .WIDTH(12),
        .DEPTH(32),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .wr_valid(wr_valid),
        .wr_data(wr_data),
        .wr_ready(wr_ready),
        .count(count),
        .underrun(underrun),
        .clr_underrun(clr_underrun),
        .duty_cycle(duty_cycle),
        .req(req),
        .ack(ack)
    );

    // DAC model: records each sample, acks three cycles after req.
    always @(posedge clk) begin
        #2;
        if (dac_auto) begin
            if (req) begin
                if (!ack) begin
                    if (req_cnt == 0) rx_q.push_back(duty_cycle);
                    req_cnt++;
                    if (req_cnt >= 3) ack = 1'b1;
                end
            end else begin
                req_cnt = 0;
                ack     = 1'b0;
            end
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        enable       = 1'b0;
        wr_valid     = 1'b0;
        clr_underrun = 1'b0;
        dac_auto     = 1'b0;
        ack          = 1'b0;
        req_cnt      = 0;
        rx_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wr(input logic [11:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [11:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            wr_valid = 1'b1;
            wr_data  = base + 12'(i);
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (req) break;
        end
        chk(tag, 32'(req), 32'd1);
    endtask

    task automatic wait_drain(input string tag, input int n,
                              input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (rx_q.size() >= n && !req && !ack) break;
        end
        repeat (8) @(negedge clk);
        chk(tag, 32'(rx_q.size()), 32'(n));
    endtask

    initial begin
        int n;
        bit seen;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_duty", 32'(duty_cycle), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;

        // Single sample, latency and handshake timing
        do_reset();
        enable = 1'b1;
        wr(12'h123);
        chk("t1_count_n", 32'(count), 32'd1);
        chk("t1_duty_n", 32'(duty_cycle), 32'd0);
        @(negedge clk);
        chk("t1_duty_n1", 32'(duty_cycle), 32'h123);
        chk("t1_req_n1", 32'(req), 32'd0);
        chk("t1_count_n1", 32'(count), 32'd0);
        @(negedge clk);
        chk("t1_req_n2", 32'(req), 32'd1);
        repeat (2) @(negedge clk);
        ack = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n = i;
            if (!req) break;
        end
        chk("t1_req_fall", 32'(n), 32'd3);
        ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_unr_pre", 32'(underrun), 32'd0);
        @(negedge clk);
        chk("t1_idle_unr", 32'(underrun), 32'd1);
        chk("t1_count_end", 32'(count), 32'd0);

        // Fill to full with enable low, overflow drop, ordered drain
        do_reset();
        wr_burst(12'h000, 32);
        chk("t2_wr_ready", 32'(wr_ready), 32'd0);
        chk("t2_count", 32'(count), 32'd32);
        wr(12'hFFF);
        chk("t2_drop", 32'(count), 32'd32);
        dac_auto = 1'b1;
        enable   = 1'b1;
        wait_drain("t2_rx_n", 32, 3000);
        for (int i = 0; i < 32 && i < rx_q.size(); i++)
            chk($sformatf("t2_rx%0d", i), 32'(rx_q[i]), 32'(i));
        chk("t2_count_end", 32'(count), 32'd0);

        // Full with coincident write and pop
        do_reset();
        wr_burst(12'h100, 32);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = 12'hAAA;
        enable   = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("t3_count31", 32'(count), 32'd31);
        dac_auto = 1'b1;
        wait_drain("t3_rx_n", 32, 3000);
        seen = 1'b0;
        foreach (rx_q[i]) if (rx_q[i] == 12'hAAA) seen = 1'b1;
        chk("t3_no_aaa", 32'(seen), 32'd0);
        if (rx_q.size() > 0)
            chk("t3_last", 32'(rx_q[rx_q.size()-1]), 32'h11F);

        // Underrun set, sticky against clear, then cleared
        do_reset();
        dac_auto = 1'b1;
        enable   = 1'b1;
        wr(12'h201);
        wr(12'h202);
        wait_drain("t4_rx_n", 2, 500);
        chk("t4_underrun", 32'(underrun), 32'd1);
        chk("t4_duty_hold", 32'(duty_cycle), 32'h202);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("t4_clr_empty", 32'(underrun), 32'd1);
        wr(12'h203);
        clr_underrun = 1'b1;
        @(negedge clk);
        clr_underrun = 1'b0;
        chk("t4_clr_ok", 32'(underrun), 32'd0);
        wait_drain("t4_rx_n2", 3, 500);
        chk("t4_reset_again", 32'(underrun), 32'd1);

        // Reset during REQ with the DAC holding ack
        do_reset();
        enable = 1'b1;
        wr(12'h3A5);
        wait_req("t5_req_up", 20);
        ack = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("t5_req_async", 32'(req), 32'd0);
        chk("t5_duty_async", 32'(duty_cycle), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        wr(12'h3A6);
        repeat (6) @(negedge clk);
        chk("t5_stale_req", 32'(req), 32'd0);
        chk("t5_stale_cnt", 32'(count), 32'd1);
        ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_req_wait", 32'(req), 32'd0);
        chk("t5_duty_new", 32'(duty_cycle), 32'h3A6);
        @(negedge clk);
        chk("t5_req_new", 32'(req), 32'd1);

        // enable dropped mid-REQ
        do_reset();
        dac_auto = 1'b1;
        enable   = 1'b1;
        wr(12'h301);
        wait_req("t6_req_up", 20);
        enable = 1'b0;
        wr_burst(12'h310, 5);
        repeat (80) @(negedge clk);
        chk("t6_rx_n", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0)
            chk("t6_rx0", 32'(rx_q[0]), 32'h301);
        chk("t6_count", 32'(count), 32'd5);
        chk("t6_req", 32'(req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_sample_feeder.md
Name: dac_sample_feeder

Overview:
- CPU-clock-domain audio sample buffer and handshake source for the PWM DAC.
- The CPU memory-mapped I/O path pushes 12-bit duty-cycle samples into an internal FIFO.
- The block pops samples one at a time and delivers each to the PWM-domain DAC through a four-phase req/ack handshake, synchronising the incoming ack.
- It sits between the Riscv151 MMIO decode and the DAC's rv_duty_cycle/req/ack interface.

Parameters:
- WIDTH, 12, sample/duty-cycle width in bits.
- DEPTH, 32, FIFO depth in entries; must be a power of 2, at least 2.
- SYNC_STAGES, 2, number of flops in the ack synchroniser; at least 2.

Ports:
- clk  in  1  CPU clock.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  allows new transfers to start.
- wr_valid  in  1  sample write strobe.
- wr_data  in  WIDTH  sample to enqueue.
- wr_ready  out  1  FIFO can accept a write this cycle.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- underrun  out  1  sticky: FIFO ran dry during playback.
- clr_underrun  in  1  clears underrun.
- duty_cycle  out  WIDTH  sample presented to the DAC.
- req  out  1  handshake request, registered.
- ack  in  1  DAC acknowledge; asynchronous to clk.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high.
  - All of the following clear immediately on rst: FIFO pointers, count=0, wr_ready=1, duty_cycle=0, req=0, underrun=0, primed=0, ack synchroniser flops=0, FSM=IDLE.
- FIFO write side:
  - wr_ready = (count != DEPTH), combinational from registered count.
  - A write is accepted on an edge where wr_valid && wr_ready.
  - Writes when full are dropped silently; count does not change.
- Simultaneous push and pop: count is unchanged, both take effect.
  - When full, a same-cycle pop does not make room for the write. wr_ready was 0, so the write is dropped and count becomes DEPTH-1.
- Pointers wrap modulo DEPTH; count is never above DEPTH and never below 0.
- ack_s is ack after SYNC_STAGES flops; the FSM uses only ack_s.
- FSM states:
  - IDLE:
    - If enable && count!=0 && ack_s==0: pop the head into duty_cycle, set primed=1, go to SETUP.
    - Otherwise stay; req=0.
  - SETUP: req=0, duty_cycle stable. Go to REQ unconditionally, so there is one cycle of data setup before req rises.
  - REQ: req=1. When ack_s==1, go to RELEASE.
  - RELEASE: req=0. When ack_s==0, go to IDLE.
- req is a registered decode of the next state: high exactly while the FSM is in REQ.
- duty_cycle changes only on the IDLE→SETUP transition and holds its last value otherwise, including across underrun.
- Latency: a write accepted at edge N into an empty FIFO (enable=1, ack_s=0) gives:
  - pop and duty_cycle update at edge N+1;
  - req=1 after edge N+2.
- Handshake: req falls one edge after ack_s is seen high. The next sample may start only after ack_s is seen low, so there is never a second req before the DAC has dropped ack.
- Throughput: at most one sample per 4+2*SYNC_STAGES cycles, plus DAC latency.
- enable deasserted mid-handshake: the current handshake completes through RELEASE, then the FSM holds in IDLE. The FIFO keeps accepting writes.
- underrun:
  - Set on any edge where FSM==IDLE && enable && primed && count==0.
  - If set and clr_underrun occur together, set wins.
  - Cleared by clr_underrun only when the set condition is false.
- Reset mid-handshake: req drops at once. After reset, IDLE waits for ack_s==0 before issuing a new req, so a stale DAC ack is never taken as a new handshake.
- ack glitching high while in IDLE or SETUP is ignored: IDLE requires ack_s==0 to start, and SETUP does not look at ack.

Test Plan:
- Reset, enable=1, write 0x123 at edge 0; bench DAC acks 3 cycles after req.
  - Required: duty_cycle=0x123 after edge 1, req=1 after edge 2, req falls one edge after ack_s rises, FSM returns to IDLE after ack drops, count=0.
- Write 32 samples 0x000..0x01F with enable=0.
  - Required: wr_ready=0 and count=32 afterwards; a 33rd write of 0xFFF is dropped.
  - Then enable=1: the DAC receives exactly 0x000..0x01F in order.
- FIFO full with a simultaneous write 0xAAA and pop.
  - Required: count=31 and 0xAAA never appears at the DAC.
- Play 2 samples then stop writing, enable=1.
  - Required: underrun=1 once IDLE is reached with the FIFO empty, and duty_cycle holds the 2nd sample.
  - clr_underrun pulse with the FIFO still empty: underrun stays 1.
  - After a write: the flag clears on the next clr_underrun.
- Assert rst while req=1 and ack held high by the DAC.
  - Required: req=0 immediately and duty_cycle=0.
  - After release with a new sample queued, req stays 0 until ack has been low for SYNC_STAGES edges.
- Drop enable during REQ.
  - Required: the handshake completes, no further req with 5 samples queued, count stays 5.
